// File: rtl/seg_capture.sv
// Reader for a multiplexed active-low 7-segment display bus.
// Reconstructs the 16-bit hex value shown on four scanned or statically driven digits.
module seg_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  a_to_g,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic [3:0]  digit_err
);

    localparam logic [10:0] IDLE      = 11'h7FF;
    localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);

    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] sync_d [SYNC_STAGES];
    logic [10:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        taken_q, taken_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_err_q, shadow_err_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  digit_err_q, digit_err_d;
    logic        valid_q, valid_d;

    logic [10:0] s;
    logic [3:0]  sel;
    logic [3:0]  nib;
    logic        glyph_err;
    logic        changed;
    logic        fire;

    assign s         = sync_q[SYNC_STAGES-1];
    assign sel       = ~s[10:7];
    assign value     = value_q;
    assign valid     = valid_q;
    assign digit_err = digit_err_q;

    always_comb begin
        sync_d[0] = {an, a_to_g};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Segment pattern to nibble; anything outside the sixteen glyphs is flagged.
    always_comb begin
        nib       = 4'h0;
        glyph_err = 1'b0;
        case (s[6:0])
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    glyph_err = 1'b1;
        endcase
    end

    always_comb begin
        prev_d       = s;
        changed      = (s != prev_q);
        cnt_d        = changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
        // cnt counts repeats after the first sighting, so SETTLE sightings means SETTLE-1.
        fire         = (cnt_d == SETTLE_M1) && (changed || !taken_q);
        taken_d      = changed ? fire : (taken_q | fire);
        mask_d       = mask_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        value_d      = value_q;
        digit_err_d  = digit_err_q;
        valid_d      = 1'b0;

        if (fire && (sel != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    shadow_d[4*i +: 4] = nib;
                    shadow_err_d[i]    = glyph_err;
                end
            end
            mask_d = mask_q | sel;
            if (mask_d == 4'b1111) begin
                value_d     = shadow_d;
                digit_err_d = shadow_err_d;
                valid_d     = 1'b1;
                mask_d      = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IDLE;
            end
            prev_q       <= IDLE;
            cnt_q        <= 8'd0;
            taken_q      <= 1'b0;
            mask_q       <= 4'b0000;
            shadow_q     <= 16'h0000;
            shadow_err_q <= 4'b0000;
            value_q      <= 16'h0000;
            digit_err_q  <= 4'b0000;
            valid_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            taken_q      <= taken_d;
            mask_q       <= mask_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            value_q      <= value_d;
            digit_err_q  <= digit_err_d;
            valid_q      <= valid_d;
        end
    end

endmodule
